// File: rtl/ivar_gen_pkg.sv
// rtl/ivar_gen_pkg.sv - shared state encoding and default widths for the ivar sequence generator
package ivar_gen_pkg;

  localparam int IVAR_W_DEF    = 16;
  localparam int NUM_DIMS_DEF  = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } ivar_state_t;

endpackage

// File: rtl/ivar_dim_counter.sv
// rtl/ivar_dim_counter.sv - one loop dimension: holds captured bounds and the current value
module ivar_dim_counter
  import ivar_gen_pkg::*;
#(
  parameter int W = IVAR_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic                adv,
  input  logic signed [W-1:0] lb,
  input  logic signed [W-1:0] ub,
  output logic signed [W-1:0] value,
  output logic                at_ub
);

  logic signed [W-1:0] r_lb;
  logic signed [W-1:0] r_ub;
  logic signed [W-1:0] r_value;
  logic        [W-1:0] w_one;

  assign w_one = {{(W-1){1'b0}}, 1'b1};
  assign value = r_value;
  // Equality against ub means the increment is never taken at the max signed value
  assign at_ub = (r_value == r_ub);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lb    <= '0;
      r_ub    <= '0;
      r_value <= '0;
    end else if (load) begin
      r_lb    <= lb;
      r_ub    <= ub;
      r_value <= lb;
    end else if (adv) begin
      r_value <= at_ub ? r_lb : (r_value + w_one);
    end
  end

endmodule

// File: rtl/ivar_sequence_generator.sv
// rtl/ivar_sequence_generator.sv - scans an N-D rectangular iteration space, one vector per handshake
module ivar_sequence_generator
  import ivar_gen_pkg::*;
#(
  parameter int ITERATION_VARIABLE_WIDTH = IVAR_W_DEF,
  parameter int NUM_DIMS                 = NUM_DIMS_DEF
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     start,
  input  logic                                     abort,
  input  logic [NUM_DIMS*ITERATION_VARIABLE_WIDTH-1:0] ivar_lb,
  input  logic [NUM_DIMS*ITERATION_VARIABLE_WIDTH-1:0] ivar_ub,
  output logic [NUM_DIMS*ITERATION_VARIABLE_WIDTH-1:0] ivar,
  output logic                                     ivar_valid,
  input  logic                                     ivar_ready,
  output logic                                     ivar_last,
  output logic                                     busy,
  output logic                                     done,
  output logic                                     empty_err
);

  localparam int W = ITERATION_VARIABLE_WIDTH;

  ivar_state_t         r_state;
  logic                r_valid;
  logic                r_busy;
  logic                r_done;
  logic                r_empty_err;

  logic [NUM_DIMS-1:0] w_at_ub;
  logic [NUM_DIMS-1:0] w_adv;
  logic                w_all_ub;
  logic                w_fire;
  logic                w_load;
  logic                w_empty;

  assign w_all_ub = &w_at_ub;
  assign w_fire   = (r_state == ST_RUN) && r_valid && ivar_ready && !abort;
  assign w_load   = (r_state == ST_IDLE) && start && !abort;

  always_comb begin
    w_empty = 1'b0;
    for (int d = 0; d < NUM_DIMS; d++) begin
      if ($signed(ivar_lb[d*W +: W]) > $signed(ivar_ub[d*W +: W])) begin
        w_empty = 1'b1;
      end
    end
  end

  // Carry chain: dim d advances only when every faster dim wraps
  genvar g;
  generate
    for (g = 0; g < NUM_DIMS; g++) begin : g_dim
      if (g == 0) begin : g_first
        assign w_adv[g] = w_fire && !w_all_ub;
      end else begin : g_rest
        assign w_adv[g] = w_adv[g-1] && w_at_ub[g-1];
      end

      ivar_dim_counter #(.W(W)) u_dim (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_load),
        .adv   (w_adv[g]),
        .lb    (ivar_lb[g*W +: W]),
        .ub    (ivar_ub[g*W +: W]),
        .value (ivar[g*W +: W]),
        .at_ub (w_at_ub[g])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_empty_err <= 1'b0;
    end else if (abort) begin
      r_state     <= ST_IDLE;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_empty_err <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done      <= 1'b0;
          r_empty_err <= 1'b0;
          if (start) begin
            if (w_empty) begin
              r_empty_err <= 1'b1;
            end else begin
              r_state <= ST_RUN;
              r_valid <= 1'b1;
              r_busy  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (w_fire && w_all_ub) begin
            r_state <= ST_DONE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign ivar_valid = r_valid;
  assign ivar_last  = r_valid && w_all_ub;
  assign busy       = r_busy;
  assign done       = r_done;
  assign empty_err  = r_empty_err;

endmodule

// File: tb/tb_ivar_sequence_generator.sv
// tb/tb_ivar_sequence_generator.sv - vector table plus randomized runs against an index-based model
module tb_ivar_sequence_generator;

  localparam int W = 16;
  localparam int D = 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic [D*W-1:0] ivar_lb = '0;
  logic [D*W-1:0] ivar_ub = '0;
  logic [D*W-1:0] ivar;
  logic           ivar_valid;
  logic           ivar_ready = 1'b0;
  logic           ivar_last;
  logic           busy;
  logic           done;
  logic           empty_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ivar_sequence_generator #(.ITERATION_VARIABLE_WIDTH(W), .NUM_DIMS(D)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .ivar_lb(ivar_lb), .ivar_ub(ivar_ub), .ivar(ivar), .ivar_valid(ivar_valid),
    .ivar_ready(ivar_ready), .ivar_last(ivar_last), .busy(busy), .done(done),
    .empty_err(empty_err)
  );

  typedef struct {
    int lb[D];
    int ub[D];
    int mode;       // 0: ready always 1, 1: random ready + noisy inputs, 2: 3-cycle stall on vector 1
    int exp_total;  // 0 means empty space
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [D*W-1:0] pack(input int v[D]);
    logic [D*W-1:0] p;
    for (int d = 0; d < D; d++) p[d*W +: W] = W'(v[d]);
    return p;
  endfunction

  // Mixed-radix decode of the k-th point in lexicographic order, dim 0 fastest
  function automatic logic [D*W-1:0] model_vec(input int lb[D], input int ub[D], input int k);
    int v[D];
    int r;
    r = k;
    for (int d = 0; d < D; d++) begin
      v[d] = lb[d] + (r % (ub[d] - lb[d] + 1));
      r    = r / (ub[d] - lb[d] + 1);
    end
    return pack(v);
  endfunction

  task automatic run_cfg(input vec_t t);
    int idx;
    int cyc;
    int stall;
    logic [D*W-1:0] last_vec;
    ivar_lb = pack(t.lb);
    ivar_ub = pack(t.ub);
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (t.exp_total == 0) begin
      chk("empty_err_pulse", empty_err, 1);
      chk("empty_no_valid", ivar_valid, 0);
      chk("empty_no_busy", busy, 0);
      @(negedge clk);
      chk("empty_err_clear", empty_err, 0);
      chk("empty_still_idle", busy, 0);
      return;
    end
    idx = 0; cyc = 0; stall = 0;
    last_vec = model_vec(t.lb, t.ub, t.exp_total - 1);
    while (idx < t.exp_total && cyc < 3000) begin
      chk("valid", ivar_valid, 1);
      chk("busy", busy, 1);
      chk("ivar", ivar, model_vec(t.lb, t.ub, idx));
      chk("last", ivar_last, (idx == t.exp_total - 1));
      case (t.mode)
        1: begin
          ivar_ready = ($urandom_range(0, 2) != 0);
          start      = ($urandom_range(0, 3) == 0);
          ivar_lb    = {$urandom, $urandom};
          ivar_ub    = {$urandom, $urandom};
        end
        2: begin
          ivar_ready = !(idx == 1 && stall < 3);
          if (!ivar_ready) stall++;
        end
        default: ivar_ready = 1'b1;
      endcase
      if (ivar_ready) idx++;
      cyc++;
      @(negedge clk);
    end
    if (cyc >= 3000) chk("run_timeout", 1, 0);
    start = 1'b0;
    ivar_ready = 1'b0;
    chk("done_pulse", done, 1);
    chk("done_valid_low", ivar_valid, 0);
    chk("done_busy_low", busy, 0);
    chk("done_ivar_held", ivar, last_vec);
    @(negedge clk);
    chk("done_clear", done, 0);
    chk("idle_ivar_held", ivar, last_vec);
  endtask

  vec_t tbl[$];

  initial begin
    vec_t t;
    // reset state
    #12;
    chk("rst_ivar", ivar, 0);
    chk("rst_valid", ivar_valid, 0);
    chk("rst_last", ivar_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", empty_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    tbl.push_back('{lb:'{0,0,0},          ub:'{2,1,0},          mode:0, exp_total:6});
    tbl.push_back('{lb:'{0,0,0},          ub:'{2,1,0},          mode:2, exp_total:6});
    tbl.push_back('{lb:'{-3,5,5},         ub:'{-1,5,5},         mode:0, exp_total:3});
    tbl.push_back('{lb:'{32766,0,0},      ub:'{32767,0,0},      mode:0, exp_total:2});
    tbl.push_back('{lb:'{0,4,0},          ub:'{1,2,0},          mode:0, exp_total:0});
    tbl.push_back('{lb:'{-2,-1,3},        ub:'{1,0,4},          mode:1, exp_total:16});
    tbl.push_back('{lb:'{-32768,7,0},     ub:'{-32767,7,1},     mode:1, exp_total:4});
    tbl.push_back('{lb:'{9,-9,32767},     ub:'{9,-9,32767},     mode:0, exp_total:1});
    tbl.push_back('{lb:'{0,0,-1},         ub:'{0,0,-2},         mode:0, exp_total:0});

    foreach (tbl[i]) run_cfg(tbl[i]);

    // randomized configurations, total from the product rule
    for (int n = 0; n < 8; n++) begin
      t.exp_total = 1;
      for (int d = 0; d < D; d++) begin
        t.lb[d] = $urandom_range(0, 200) - 100;
        t.ub[d] = t.lb[d] + $urandom_range(0, 3);
        if (n == 3 && d == 0) begin t.lb[d] = 32765; t.ub[d] = 32767; end
        t.exp_total *= (t.ub[d] - t.lb[d] + 1);
      end
      t.mode = 1;
      run_cfg(t);
    end

    // abort on the 3rd vector
    ivar_lb = pack('{0,0,0});
    ivar_ub = pack('{2,1,0});
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ivar_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("abort_pre_vec", ivar, pack('{2,0,0}));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    ivar_ready = 1'b0;
    chk("abort_valid", ivar_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_last", ivar_last, 0);
    chk("abort_done", done, 0);
    @(negedge clk);
    chk("abort_no_done", done, 0);
    chk("abort_idle", ivar_valid, 0);

    // abort and start together in IDLE: abort wins
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("abort_start_valid", ivar_valid, 0);
    chk("abort_start_busy", busy, 0);
    @(negedge clk);
    chk("abort_start_idle", busy, 0);

    // async reset mid-run
    ivar_lb = pack('{0,0,0});
    ivar_ub = pack('{2,1,0});
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ivar_ready = 1'b1;
    @(negedge clk);
    ivar_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ivar", ivar, 0);
    chk("arst_valid", ivar_valid, 0);
    chk("arst_last", ivar_last, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_cfg(tbl[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
